// File: rtl/video_timing_pkg.sv
// Preset video modes for the timing generator and the active-window helper
// used by both the DE and the early-DE decode.
package video_timing_pkg;

  localparam int TBL_W = 12;

  typedef struct packed {
    logic [TBL_W-1:0] h_total;
    logic [TBL_W-1:0] h_sync;
    logic [TBL_W-1:0] h_bporch;
    logic [TBL_W-1:0] h_res;
    logic [TBL_W-1:0] v_total;
    logic [TBL_W-1:0] v_sync;
    logic [TBL_W-1:0] v_bporch;
    logic [TBL_W-1:0] v_res;
    logic             hs_pol;
    logic             vs_pol;
  } mode_t;

  typedef mode_t [0:3] mode_tbl_t;

  // Field order: h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res, hs_pol, vs_pol
  localparam mode_tbl_t MODE_TABLE = '{
    '{12'd1650, 12'd40,  12'd220, 12'd640,  12'd750, 12'd5, 12'd20, 12'd480, 1'b1, 1'b1},
    '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1},
    '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0},
    '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1}
  };

  // True when start <= cnt < start + len.
  function automatic logic de_window(input logic [31:0] cnt,
                                     input logic [31:0] start,
                                     input logic [31:0] len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Table-driven video timing generator: HS/VS/DE, early DE, coordinates,
// line/frame strobes and a completed-frame counter, all registered.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int        H_W         = 12,
  parameter int        V_W         = 12,
  parameter int        NUM_MODES   = 4,
  parameter int        DE_LEAD     = 2,
  parameter int        FRAME_CNT_W = 16,
  parameter mode_tbl_t MODES       = MODE_TABLE
) (
  input  logic                   I_pxl_clk,
  input  logic                   I_rst_n,
  input  logic [1:0]             I_mode,
  output logic [1:0]             O_mode,
  output logic                   O_hs,
  output logic                   O_vs,
  output logic                   O_de,
  output logic                   O_de_early,
  output logic [H_W-1:0]         O_x,
  output logic [V_W-1:0]         O_y,
  output logic                   O_line_start,
  output logic                   O_frame_start,
  output logic [FRAME_CNT_W-1:0] O_frame_cnt
);

  if (NUM_MODES < 1 || NUM_MODES > 4) begin : g_num_modes_err
    $error("NUM_MODES must be in 1..4");
  end

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_lead_chk
    if (int'(MODES[gi].h_sync) + int'(MODES[gi].h_bporch) < DE_LEAD) begin : g_err
      $error("DE_LEAD exceeds the horizontal blanking of a preset mode");
    end
  end

  mode_t                  cur;
  logic [1:0]             mode_q, mode_d, mode_sel;
  logic [H_W-1:0]         h_cnt_q, h_cnt_d;
  logic [V_W-1:0]         v_cnt_q, v_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]            h_cnt_w, v_cnt_w, hb, vb;
  logic                   h_last, v_last, v_in, hs_act, vs_act, de, de_early;

  logic [1:0]             mode_o_q;
  logic                   hs_q, vs_q, de_q, de_early_q, line_start_q, frame_start_q;
  logic [H_W-1:0]         x_q;
  logic [V_W-1:0]         y_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_o_q;

  assign cur     = MODES[mode_q];
  assign h_cnt_w = 32'(h_cnt_q);
  assign v_cnt_w = 32'(v_cnt_q);
  assign hb      = 32'(cur.h_sync) + 32'(cur.h_bporch);
  assign vb      = 32'(cur.v_sync) + 32'(cur.v_bporch);
  assign h_last  = (h_cnt_w == 32'(cur.h_total) - 32'd1);
  assign v_last  = (v_cnt_w == 32'(cur.v_total) - 32'd1);

  assign hs_act   = (h_cnt_w < 32'(cur.h_sync));
  assign vs_act   = (v_cnt_w < 32'(cur.v_sync));
  assign v_in     = de_window(v_cnt_w, vb, 32'(cur.v_res));
  assign de       = v_in && de_window(h_cnt_w, hb, 32'(cur.h_res));
  // Only the horizontal window moves earlier; line selection is identical to DE.
  assign de_early = v_in && de_window(h_cnt_w, hb - 32'(DE_LEAD), 32'(cur.h_res));

  assign mode_sel = (int'(I_mode) < NUM_MODES) ? I_mode : 2'd0;

  always_comb begin
    h_cnt_d     = h_cnt_q + H_W'(1);
    v_cnt_d     = v_cnt_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      if (v_last) begin
        v_cnt_d     = '0;
        mode_d      = mode_sel;
        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end else begin
        v_cnt_d = v_cnt_q + V_W'(1);
      end
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= '0;
      frame_cnt_q   <= '0;
      mode_o_q      <= '0;
      hs_q          <= ~MODES[0].hs_pol;
      vs_q          <= ~MODES[0].vs_pol;
      de_q          <= 1'b0;
      de_early_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_o_q <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_o_q      <= mode_q;
      hs_q          <= ~(hs_act ^ cur.hs_pol);
      vs_q          <= ~(vs_act ^ cur.vs_pol);
      de_q          <= de;
      de_early_q    <= de_early;
      x_q           <= de ? H_W'(h_cnt_w - hb) : '0;
      y_q           <= de ? V_W'(v_cnt_w - vb) : '0;
      line_start_q  <= (h_cnt_q == '0);
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      frame_cnt_o_q <= frame_cnt_q;
    end
  end

  assign O_mode        = mode_o_q;
  assign O_hs          = hs_q;
  assign O_vs          = vs_q;
  assign O_de          = de_q;
  assign O_de_early    = de_early_q;
  assign O_x           = x_q;
  assign O_y           = y_q;
  assign O_line_start  = line_start_q;
  assign O_frame_start = frame_start_q;
  assign O_frame_cnt   = frame_cnt_o_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized mode-request bench for video_timing_gen against a frame-position model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  // Small timings so many frames fit in a short run; mode 3 is never reachable (NUM_MODES=3).
  localparam mode_tbl_t TB_MODES = '{
    '{12'd20, 12'd3, 12'd4, 12'd8,  12'd10, 12'd2, 12'd2, 12'd4, 1'b1, 1'b1},
    '{12'd16, 12'd2, 12'd3, 12'd6,  12'd8,  12'd1, 12'd2, 12'd3, 1'b0, 1'b0},
    '{12'd24, 12'd4, 12'd5, 12'd10, 12'd9,  12'd2, 12'd1, 12'd5, 1'b0, 1'b1},
    '{12'd18, 12'd3, 12'd3, 12'd9,  12'd7,  12'd1, 12'd1, 12'd4, 1'b1, 1'b0}
  };
  localparam mode_tbl_t DEF_MODES = '{
    '{12'd1650, 12'd40,  12'd220, 12'd640,  12'd750, 12'd5, 12'd20, 12'd480, 1'b1, 1'b1},
    '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1},
    '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0},
    '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1}
  };
  localparam int LEAD = 2;

  logic        clk, rst_n;
  logic [1:0]  i_mode;

  logic [1:0]  a_mode, b_mode;
  logic        a_hs, a_vs, a_de, a_dee, a_ls, a_fs;
  logic        b_hs, b_vs, b_de, b_dee, b_ls, b_fs;
  logic [11:0] a_x, a_y, b_x, b_y;
  logic [3:0]  a_fc;
  logic [15:0] b_fc;

  logic [47:0] exp_qa[$];
  logic [47:0] exp_qb[$];
  int total, bad, printed;
  int a_t, a_m, a_f, b_t, b_m, b_f;
  int prev_fc;
  bit seen_wrap, seen_sw2;

  video_timing_gen #(
    .H_W(12), .V_W(12), .NUM_MODES(3), .DE_LEAD(LEAD), .FRAME_CNT_W(4), .MODES(TB_MODES)
  ) dut (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_mode(i_mode), .O_mode(a_mode),
    .O_hs(a_hs), .O_vs(a_vs), .O_de(a_de), .O_de_early(a_dee), .O_x(a_x), .O_y(a_y),
    .O_line_start(a_ls), .O_frame_start(a_fs), .O_frame_cnt(a_fc)
  );

  video_timing_gen dut_def (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_mode(i_mode), .O_mode(b_mode),
    .O_hs(b_hs), .O_vs(b_vs), .O_de(b_de), .O_de_early(b_dee), .O_x(b_x), .O_y(b_y),
    .O_line_start(b_ls), .O_frame_start(b_fs), .O_frame_cnt(b_fc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pack(input logic [1:0] m, input logic hs, input logic vs,
                                       input logic de, input logic dee, input logic [11:0] x,
                                       input logic [11:0] y, input logic ls, input logic fs,
                                       input logic [15:0] fc);
    return {m, hs, vs, de, dee, x, y, ls, fs, fc};
  endfunction

  function automatic int frame_len(input mode_t md);
    return int'(md.h_total) * int'(md.v_total);
  endfunction

  // Expected outputs for position t (cycles since frame start) of a frame in mode m.
  function automatic logic [47:0] model_out(input mode_t md, input int m, input int t,
                                            input int fc);
    int h, v, hb, vb, x, y;
    bit vin, de, dee, hs, vs;
    h   = t % int'(md.h_total);
    v   = t / int'(md.h_total);
    hb  = int'(md.h_sync) + int'(md.h_bporch);
    vb  = int'(md.v_sync) + int'(md.v_bporch);
    vin = (v >= vb) && (v < vb + int'(md.v_res));
    de  = vin && (h >= hb) && (h < hb + int'(md.h_res));
    dee = vin && (h >= hb - LEAD) && (h < hb + int'(md.h_res) - LEAD);
    hs  = (h < int'(md.h_sync)) == md.hs_pol;
    vs  = (v < int'(md.v_sync)) == md.vs_pol;
    x   = de ? h - hb : 0;
    y   = de ? v - vb : 0;
    return pack(2'(m), hs, vs, de, dee, 12'(x), 12'(y), h == 0, t == 0, 16'(fc));
  endfunction

  task automatic check(input string nm, input logic [47:0] got, input logic [47:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (printed < 20) begin
        printed++;
        $display("FAIL %s at %0t: got=%h want=%h", nm, $time, got, want);
      end
    end
  endtask

  // reference models: push the expected output for each clock edge
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        a_t = 0; a_m = 0; a_f = 0;
        exp_qa.delete();
      end else begin
        exp_qa.push_back(model_out(TB_MODES[a_m], a_m, a_t, a_f));
        if (a_t == frame_len(TB_MODES[a_m]) - 1) begin
          a_t = 0;
          a_f = (a_f + 1) % 16;
          a_m = (int'(i_mode) < 3) ? int'(i_mode) : 0;
        end else a_t++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        b_t = 0; b_m = 0; b_f = 0;
        exp_qb.delete();
      end else begin
        exp_qb.push_back(model_out(DEF_MODES[b_m], b_m, b_t, b_f));
        if (b_t == frame_len(DEF_MODES[b_m]) - 1) begin
          b_t = 0;
          b_f = (b_f + 1) % 65536;
          b_m = int'(i_mode);
        end else b_t++;
      end
    end
  end

  // monitors
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("a_reset", pack(a_mode, a_hs, a_vs, a_de, a_dee, a_x, a_y, a_ls, a_fs, 16'(a_fc)),
              pack(2'd0, ~TB_MODES[0].hs_pol, ~TB_MODES[0].vs_pol, 1'b0, 1'b0, 12'd0, 12'd0,
                   1'b0, 1'b0, 16'd0));
        check("b_reset", pack(b_mode, b_hs, b_vs, b_de, b_dee, b_x, b_y, b_ls, b_fs, b_fc),
              pack(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 16'd0));
      end else begin
        if (exp_qa.size() > 0)
          check("a_out", pack(a_mode, a_hs, a_vs, a_de, a_dee, a_x, a_y, a_ls, a_fs, 16'(a_fc)),
                exp_qa.pop_front());
        if (exp_qb.size() > 0)
          check("b_out", pack(b_mode, b_hs, b_vs, b_de, b_dee, b_x, b_y, b_ls, b_fs, b_fc),
                exp_qb.pop_front());
        if (a_fs) begin
          if (a_fc == 4'd0 && prev_fc == 15) seen_wrap = 1'b1;
          if (a_mode == 2'd2) seen_sw2 = 1'b1;
          prev_fc = int'(a_fc);
        end
      end
    end
  end

  task automatic run_random(input int iters);
    for (int i = 0; i < iters; i++) begin
      repeat ($urandom_range(10, 400)) @(negedge clk);
      i_mode = 2'($urandom_range(0, 3));
    end
  endtask

  // driver
  initial begin
    int n;
    total = 0; bad = 0; printed = 0; prev_fc = -1;
    seen_wrap = 1'b0; seen_sw2 = 1'b0;
    rst_n  = 1'b0;
    i_mode = 2'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // request changes mid-frame; only the value at the frame's last cycle matters
    repeat (300) @(negedge clk);
    i_mode = 2'd2;
    repeat (30) @(negedge clk);
    i_mode = 2'd1;
    repeat (30) @(negedge clk);
    i_mode = 2'd2;
    repeat (600) @(negedge clk);
    i_mode = 2'd3;
    repeat (450) @(negedge clk);

    run_random(25);

    // asynchronous reset in the middle of an active line
    n = 0;
    while (!a_de && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("de_wait", 48'(a_de), 48'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_de", 48'(a_de), 48'd0);
    check("rst_x", 48'(a_x), 48'd0);
    check("rst_fc", 48'(a_fc), 48'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    run_random(20);
    repeat (10) @(negedge clk);

    check("fc_wrap_seen", 48'(seen_wrap), 48'd1);
    check("mode2_seen", 48'(seen_sw2), 48'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
